// File: rtl/psram_model_pkg.sv
// Shared command encodings and FSM state type for the PSRAM user-side model.
package psram_model_pkg;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        WRITE,
        READ_WAIT,
        READ_DATA,
        RECOVER
    } state_t;

endpackage

// File: rtl/psram_model_mem.sv
// Single-port word array with per-byte write enables and a one-cycle registered read.
// Contents are never reset so data survives an interface reset.
module psram_model_mem #(
    parameter int DATA_W     = 64,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                    i_clk,
    input  logic [DEPTH_LOG2-1:0]   i_addr,
    input  logic                    i_we,
    input  logic [DATA_W/8-1:0]     i_be,
    input  logic [DATA_W-1:0]       i_wdata,
    output logic [DATA_W-1:0]       o_rdata
);

    localparam int DEPTH  = 1 << DEPTH_LOG2;
    localparam int BYTE_N = DATA_W / 8;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < BYTE_N; b++) begin
                if (i_be[b]) begin
                    mem_q[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
        rdata_q <= mem_q[i_addr];
    end

    assign o_rdata = rdata_q;

endmodule

// File: rtl/psram_if_model.sv
// Cycle-level stand-in for the PSRAM HS user interface: accepts write/read bursts,
// stores them byte-masked, and returns read beats a fixed latency after accept.
module psram_if_model
    import psram_model_pkg::*;
#(
    parameter int ADDR_W       = 21,
    parameter int DATA_W       = 64,
    parameter int DEPTH_LOG2   = 10,
    parameter int BURST_BEATS  = 4,
    parameter int READ_LATENCY = 8,
    parameter int CMD_CYCLES   = 14,
    parameter int INIT_CYCLES  = 64
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_cmd,
    input  logic                  i_cmd_en,
    input  logic [ADDR_W-1:0]     i_addr,
    input  logic [DATA_W-1:0]     i_wr_data,
    input  logic [DATA_W/8-1:0]   i_data_mask,
    output logic [DATA_W-1:0]     o_rd_data,
    output logic                  o_rd_data_valid,
    output logic                  o_init_calib,
    output logic                  o_cmd_err
);

    localparam int MASK_W = DATA_W / 8;
    localparam int BEAT_W = $clog2(BURST_BEATS + 1);
    localparam int GAP_W  = $clog2(CMD_CYCLES + 1) + 1;
    localparam int INIT_W = $clog2(INIT_CYCLES + 1);

    state_t                 state_q, state_d;
    logic [DEPTH_LOG2-1:0]  addr_q, addr_d;
    logic [BEAT_W-1:0]      beat_q, beat_d;
    logic [GAP_W-1:0]       gap_q, gap_d;
    logic [INIT_W-1:0]      init_cnt_q, init_cnt_d;
    logic                   calib_q, calib_d;
    logic                   rd_vld_q, rd_vld_d;
    logic [DATA_W-1:0]      rd_data_q, rd_data_d;
    logic                   cmd_err_q, cmd_err_d;

    logic [DEPTH_LOG2-1:0]  mem_addr;
    logic                   mem_we;
    logic [MASK_W-1:0]      mem_be;
    logic [DATA_W-1:0]      mem_rdata;

    logic [DEPTH_LOG2-1:0]  cmd_addr;
    logic                   last_beat;
    logic                   gap_done;
    state_t                 burst_exit;
    logic                   unused_addr_hi;

    assign cmd_addr       = i_addr[DEPTH_LOG2-1:0];
    assign unused_addr_hi = ^i_addr[ADDR_W-1:DEPTH_LOG2];
    assign last_beat      = (beat_q == BEAT_W'(BURST_BEATS - 1));
    // The gap counter advances on the same edge that leaves RECOVER, so exit one count early.
    assign gap_done       = (gap_q >= GAP_W'(CMD_CYCLES - 1));
    assign burst_exit     = gap_done ? IDLE : RECOVER;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        beat_d     = beat_q;
        gap_d      = gap_q;
        init_cnt_d = init_cnt_q;
        calib_d    = calib_q;
        rd_vld_d   = 1'b0;
        rd_data_d  = rd_data_q;
        cmd_err_d  = 1'b0;
        mem_addr   = addr_q;
        mem_we     = 1'b0;
        mem_be     = '0;

        if (i_cmd_en && (state_q != IDLE)) begin
            cmd_err_d = 1'b1;
        end
        if ((state_q != INIT) && (state_q != IDLE)) begin
            gap_d = gap_q + GAP_W'(1);
        end

        case (state_q)
            INIT: begin
                if (init_cnt_q == INIT_W'(INIT_CYCLES - 1)) begin
                    calib_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    init_cnt_d = init_cnt_q + INIT_W'(1);
                end
            end
            IDLE: begin
                mem_addr = cmd_addr;
                if (i_cmd_en) begin
                    addr_d = cmd_addr;
                    gap_d  = GAP_W'(1);
                    if (i_cmd == CMD_READ) begin
                        beat_d  = '0;
                        state_d = (READ_LATENCY == 1) ? READ_DATA : READ_WAIT;
                    end else begin
                        mem_we  = 1'b1;
                        mem_be  = ~i_data_mask;
                        beat_d  = BEAT_W'(1);
                        state_d = (BURST_BEATS == 1) ? RECOVER : WRITE;
                    end
                end
            end
            WRITE: begin
                mem_addr = addr_q + DEPTH_LOG2'(beat_q);
                mem_we   = 1'b1;
                mem_be   = ~i_data_mask;
                beat_d   = beat_q + BEAT_W'(1);
                if (last_beat) begin
                    state_d = burst_exit;
                end
            end
            READ_WAIT: begin
                // Array read for beat 0 launches here so beat 0 registers exactly on time.
                mem_addr = addr_q;
                if (gap_q == GAP_W'(READ_LATENCY - 1)) begin
                    beat_d  = '0;
                    state_d = READ_DATA;
                end
            end
            READ_DATA: begin
                mem_addr  = addr_q + DEPTH_LOG2'(beat_q) + DEPTH_LOG2'(1);
                rd_vld_d  = 1'b1;
                rd_data_d = mem_rdata;
                beat_d    = beat_q + BEAT_W'(1);
                if (last_beat) begin
                    state_d = burst_exit;
                end
            end
            RECOVER: begin
                if (gap_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= INIT;
            addr_q     <= '0;
            beat_q     <= '0;
            gap_q      <= '0;
            init_cnt_q <= '0;
            calib_q    <= 1'b0;
            rd_vld_q   <= 1'b0;
            rd_data_q  <= '0;
            cmd_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            beat_q     <= beat_d;
            gap_q      <= gap_d;
            init_cnt_q <= init_cnt_d;
            calib_q    <= calib_d;
            rd_vld_q   <= rd_vld_d;
            rd_data_q  <= rd_data_d;
            cmd_err_q  <= cmd_err_d;
        end
    end

    psram_model_mem #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_mem (
        .i_clk   (i_clk),
        .i_addr  (mem_addr),
        .i_we    (mem_we && !i_rst),
        .i_be    (mem_be),
        .i_wdata (i_wr_data),
        .o_rdata (mem_rdata)
    );

    assign o_rd_data       = rd_data_q;
    assign o_rd_data_valid = rd_vld_q;
    assign o_init_calib    = calib_q;
    assign o_cmd_err       = cmd_err_q;

endmodule
